// File: rtl/axi_interconnect_nx1_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_interconnect_nx1_if
// Purpose : AXI4 bundle of N flattened lanes (lane i at slice i); N=1 for the slave port.
// Rev     : 1.0  initial release
// ============================================================================
interface axi_interconnect_nx1_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N*ADDR_W-1:0]   awaddr;
  logic [N*8-1:0]        awlen;
  logic [N*3-1:0]        awsize;
  logic [N*2-1:0]        awburst;
  logic [N-1:0]          awvalid;
  logic [N-1:0]          awready;
  logic [N*DATA_W-1:0]   wdata;
  logic [N*DATA_W/8-1:0] wstrb;
  logic [N-1:0]          wlast;
  logic [N-1:0]          wvalid;
  logic [N-1:0]          wready;
  logic [N*2-1:0]        bresp;
  logic [N-1:0]          bvalid;
  logic [N-1:0]          bready;
  logic [N*ADDR_W-1:0]   araddr;
  logic [N*8-1:0]        arlen;
  logic [N*3-1:0]        arsize;
  logic [N*2-1:0]        arburst;
  logic [N-1:0]          arvalid;
  logic [N-1:0]          arready;
  logic [N*DATA_W-1:0]   rdata;
  logic [N*2-1:0]        rresp;
  logic [N-1:0]          rlast;
  logic [N-1:0]          rvalid;
  logic [N-1:0]          rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_interconnect_nx1.sv
`default_nettype none
// ============================================================================
// Module  : axi_interconnect_nx1
// Purpose : NUM_M-master to single-slave AXI4 interconnect, round-robin per path.
// Rev     : 1.0  initial release
// ============================================================================
module axi_interconnect_nx1 #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire                    clk,
  input  wire                    rst,
  axi_interconnect_nx1_if.slave  s_bus,
  axi_interconnect_nx1_if.master m_bus,
  output logic                   wlast_err
);
  localparam int c_gw = $clog2(NUM_M);
  localparam int c_sw = DATA_W / 8;
  localparam logic [c_gw-1:0] c_last_idx = c_gw'(NUM_M - 1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

  w_state_t        r_wstate, w_wstate_nxt;
  r_state_t        r_rstate, w_rstate_nxt;
  logic [c_gw-1:0] r_wgrant, r_wptr, r_rgrant, r_rptr, w_wpick, w_rpick;
  logic [7:0]      r_beat_cnt;
  logic            w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // First requester at or after the pointer, wrapping.
  function automatic logic [c_gw-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                               input logic [c_gw-1:0] ptr);
    logic [c_gw-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = (int'(ptr) + i) % NUM_M;
      if (!found && req[idx]) begin
        pick  = c_gw'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_wpick = rr_pick(s_bus.awvalid, r_wptr);
  assign w_rpick = rr_pick(s_bus.arvalid, r_rptr);

  assign w_aw_hs = m_bus.awvalid[0] & m_bus.awready[0];
  assign w_w_hs  = m_bus.wvalid[0]  & m_bus.wready[0];
  assign w_b_hs  = m_bus.bvalid[0]  & m_bus.bready[0];
  assign w_ar_hs = m_bus.arvalid[0] & m_bus.arready[0];
  assign w_r_hs  = m_bus.rvalid[0]  & m_bus.rready[0];

  // Response payloads are broadcast; only the valids are steered.
  assign s_bus.bresp = {NUM_M{m_bus.bresp}};
  assign s_bus.rdata = {NUM_M{m_bus.rdata}};
  assign s_bus.rresp = {NUM_M{m_bus.rresp}};
  assign s_bus.rlast = {NUM_M{m_bus.rlast}};

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (|s_bus.awvalid)            w_wstate_nxt = W_ADDR;
      W_ADDR:  if (w_aw_hs)                   w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && m_bus.wlast[0])  w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs)                    w_wstate_nxt = W_IDLE;
      default:                                w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    m_bus.awaddr  = s_bus.awaddr[r_wgrant*ADDR_W +: ADDR_W];
    m_bus.awlen   = s_bus.awlen[r_wgrant*8 +: 8];
    m_bus.awsize  = s_bus.awsize[r_wgrant*3 +: 3];
    m_bus.awburst = s_bus.awburst[r_wgrant*2 +: 2];
    m_bus.wdata   = s_bus.wdata[r_wgrant*DATA_W +: DATA_W];
    m_bus.wstrb   = s_bus.wstrb[r_wgrant*c_sw +: c_sw];
    m_bus.wlast   = s_bus.wlast[r_wgrant];
    m_bus.awvalid = 1'b0;
    m_bus.wvalid  = 1'b0;
    m_bus.bready  = 1'b0;
    s_bus.awready = '0;
    s_bus.wready  = '0;
    s_bus.bvalid  = '0;
    case (r_wstate)
      W_ADDR: begin
        m_bus.awvalid           = s_bus.awvalid[r_wgrant];
        s_bus.awready[r_wgrant] = m_bus.awready[0];
      end
      W_DATA: begin
        m_bus.wvalid            = s_bus.wvalid[r_wgrant];
        s_bus.wready[r_wgrant]  = m_bus.wready[0];
      end
      W_RESP: begin
        s_bus.bvalid[r_wgrant]  = m_bus.bvalid[0];
        m_bus.bready            = s_bus.bready[r_wgrant];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate   <= W_IDLE;
      r_wgrant   <= '0;
      r_wptr     <= '0;
      r_beat_cnt <= 8'd0;
      wlast_err  <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (r_wstate == W_IDLE && |s_bus.awvalid) r_wgrant <= w_wpick;
      if (w_aw_hs) r_beat_cnt <= m_bus.awlen;
      // A mismatch is only recorded; the burst still ends on the master's wlast.
      if (w_w_hs) begin
        if (m_bus.wlast[0] != (r_beat_cnt == 8'd0)) wlast_err <= 1'b1;
        if (r_beat_cnt != 8'd0) r_beat_cnt <= r_beat_cnt - 8'd1;
      end
      if (w_b_hs) r_wptr <= (r_wgrant == c_last_idx) ? '0 : r_wgrant + 1'b1;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (|s_bus.arvalid)            w_rstate_nxt = R_ADDR;
      R_ADDR:  if (w_ar_hs)                   w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && m_bus.rlast[0])  w_rstate_nxt = R_IDLE;
      default:                                w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    m_bus.araddr  = s_bus.araddr[r_rgrant*ADDR_W +: ADDR_W];
    m_bus.arlen   = s_bus.arlen[r_rgrant*8 +: 8];
    m_bus.arsize  = s_bus.arsize[r_rgrant*3 +: 3];
    m_bus.arburst = s_bus.arburst[r_rgrant*2 +: 2];
    m_bus.arvalid = 1'b0;
    m_bus.rready  = 1'b0;
    s_bus.arready = '0;
    s_bus.rvalid  = '0;
    case (r_rstate)
      R_ADDR: begin
        m_bus.arvalid           = s_bus.arvalid[r_rgrant];
        s_bus.arready[r_rgrant] = m_bus.arready[0];
      end
      R_DATA: begin
        s_bus.rvalid[r_rgrant]  = m_bus.rvalid[0];
        m_bus.rready            = s_bus.rready[r_rgrant];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_rgrant <= '0;
      r_rptr   <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (r_rstate == R_IDLE && |s_bus.arvalid) r_rgrant <= w_rpick;
      if (w_r_hs && m_bus.rlast[0]) r_rptr <= (r_rgrant == c_last_idx) ? '0 : r_rgrant + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_interconnect_nx1.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_interconnect_nx1
// Purpose : Scoreboard bench: 2-master directed scenarios plus a 4-master grant-order check.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axi_interconnect_nx1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wlast_err, wlast_err4;
  always #5 clk = ~clk;

  axi_interconnect_nx1_if #(.N(2), .ADDR_W(32), .DATA_W(32)) sb ();
  axi_interconnect_nx1_if #(.N(1), .ADDR_W(32), .DATA_W(32)) mb ();
  axi_interconnect_nx1_if #(.N(4), .ADDR_W(32), .DATA_W(64)) sb4 ();
  axi_interconnect_nx1_if #(.N(1), .ADDR_W(32), .DATA_W(64)) mb4 ();

  axi_interconnect_nx1 #(.NUM_M(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .s_bus(sb), .m_bus(mb), .wlast_err(wlast_err));
  axi_interconnect_nx1 #(.NUM_M(4), .ADDR_W(32), .DATA_W(64)) dut4 (
    .clk(clk), .rst(rst), .s_bus(sb4), .m_bus(mb4), .wlast_err(wlast_err4));

  typedef struct {logic [31:0] data; logic last;} w_exp_t;
  typedef struct {int m; logic [31:0] data; logic last;} r_exp_t;

  int errors = 0;
  int checks = 0;
  int w_seen = 0;
  w_exp_t      exp_w[$];
  r_exp_t      exp_r[$];
  int          exp_b[$];
  logic [31:0] exp_aw[$];
  logic [31:0] g4_aw[$];
  logic [31:0] g4_ar[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic hs(input int kind, input int mi);
    case (kind)
      0:       return sb.awvalid[mi] & sb.awready[mi];
      1:       return sb.wvalid[mi]  & sb.wready[mi];
      2:       return sb.bvalid[mi]  & sb.bready[mi];
      3:       return sb.arvalid[mi] & sb.arready[mi];
      default: return sb.rvalid[mi]  & sb.rready[mi];
    endcase
  endfunction

  task automatic wait_hs(input int kind, input int mi, input string name);
    int n = 0;
    @(negedge clk);
    while (!hs(kind, mi) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hs(kind, mi)) flag(name, "handshake timeout");
  endtask

  function automatic logic [14:0] all_sigs();
    return {sb.awready, sb.wready, sb.bvalid, sb.arready, sb.rvalid,
            mb.awvalid, mb.wvalid, mb.bready, mb.arvalid, mb.rready};
  endfunction

  task automatic push_w(input logic [31:0] base, input int last_at);
    for (int b = 0; b <= last_at; b++) exp_w.push_back('{base + b, b == last_at});
  endtask

  task automatic do_write(input int mi, input logic [31:0] addr, input int len,
                          input int last_at, input logic [31:0] dbase);
    sb.awaddr[mi*32 +: 32] = addr;
    sb.awlen[mi*8 +: 8]    = len[7:0];
    sb.awvalid[mi]         = 1'b1;
    wait_hs(0, mi, "aw_wait");
    @(posedge clk); #1;
    sb.awvalid[mi] = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      sb.wdata[mi*32 +: 32] = dbase + b;
      sb.wlast[mi]          = (b == last_at);
      sb.wvalid[mi]         = 1'b1;
      wait_hs(1, mi, "w_wait");
      @(posedge clk); #1;
    end
    sb.wvalid[mi] = 1'b0;
    sb.wlast[mi]  = 1'b0;
    sb.bready[mi] = 1'b1;
    wait_hs(2, mi, "b_wait");
    @(posedge clk); #1;
    sb.bready[mi] = 1'b0;
  endtask

  task automatic do_read(input int mi, input logic [31:0] addr, input int len);
    sb.araddr[mi*32 +: 32] = addr;
    sb.arlen[mi*8 +: 8]    = len[7:0];
    sb.arvalid[mi]         = 1'b1;
    wait_hs(3, mi, "ar_wait");
    @(posedge clk); #1;
    sb.arvalid[mi] = 1'b0;
    sb.rready[mi]  = 1'b1;
    for (int b = 0; b <= len; b++) wait_hs(4, mi, "r_wait");
    @(posedge clk); #1;
    sb.rready[mi] = 1'b0;
  endtask

  // Slave model: inputs change only at posedge+1, handshakes are observed at negedge.
  initial begin
    logic        w_last_hs, b_hs, ar_hs, r_hs;
    logic [31:0] ar_addr, r_base;
    int          ar_len, r_len, r_beat;
    mb.awready = 1'b1; mb.arready = 1'b1;
    mb.bresp = 2'b00; mb.bvalid = 1'b0;
    mb.rdata = '0; mb.rresp = 2'b00; mb.rlast = 1'b0; mb.rvalid = 1'b0;
    r_base = '0; r_len = 0; r_beat = 0;
    forever begin
      @(negedge clk);
      w_last_hs = mb.wvalid[0] & mb.wready[0] & mb.wlast[0];
      b_hs      = mb.bvalid[0] & mb.bready[0];
      ar_hs     = mb.arvalid[0] & mb.arready[0];
      r_hs      = mb.rvalid[0] & mb.rready[0];
      ar_addr   = mb.araddr;
      ar_len    = int'(mb.arlen);
      @(posedge clk); #1;
      if (!rst) begin
        mb.bvalid = 1'b0; mb.rvalid = 1'b0; mb.rlast = 1'b0;
      end else begin
        if (b_hs) mb.bvalid = 1'b0;
        if (w_last_hs) mb.bvalid = 1'b1;
        if (r_hs) begin
          if (mb.rlast[0]) begin
            mb.rvalid = 1'b0; mb.rlast = 1'b0;
          end else begin
            r_beat++;
            mb.rdata = r_base + r_beat;
            mb.rlast = (r_beat == r_len);
          end
        end
        if (ar_hs) begin
          r_base = ar_addr; r_len = ar_len; r_beat = 0;
          mb.rvalid = 1'b1; mb.rdata = ar_addr; mb.rlast = (ar_len == 0);
        end
      end
    end
  end

  // Monitors: pop the scoreboard whenever the DUT presents a transfer.
  always @(negedge clk) begin
    w_exp_t e;
    if (mb.wvalid[0] && mb.wready[0]) begin
      if (exp_w.size() == 0) flag("w_beat", "unexpected beat at slave");
      else begin
        e = exp_w.pop_front();
        check("w_data", mb.wdata, e.data);
        check("w_last", mb.wlast, e.last);
      end
      w_seen++;
    end
  end

  always @(negedge clk) begin
    if (mb.awvalid[0] && mb.awready[0]) begin
      if (exp_aw.size() == 0) flag("aw_addr", "unexpected AW at slave");
      else check("aw_addr", mb.awaddr, exp_aw.pop_front());
    end
  end

  always @(negedge clk) begin
    if (|sb.bvalid) begin
      if (exp_b.size() == 0) flag("b_route", "unexpected bvalid");
      else begin
        check("b_route", sb.bvalid, 64'd1 << exp_b[0]);
        if (|(sb.bvalid & sb.bready)) begin
          check("b_resp", sb.bresp[exp_b[0]*2 +: 2], 64'd0);
          void'(exp_b.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    r_exp_t e;
    if (|sb.rvalid) begin
      if (exp_r.size() == 0) flag("r_route", "unexpected rvalid");
      else begin
        check("r_route", sb.rvalid, 64'd1 << exp_r[0].m);
        if (|(sb.rvalid & sb.rready)) begin
          e = exp_r.pop_front();
          check("r_data", sb.rdata[e.m*32 +: 32], e.data);
          check("r_last", sb.rlast[e.m], e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mb4.awvalid[0] && mb4.awready[0] && g4_aw.size() > 0) check("grant4_aw", mb4.awaddr, g4_aw.pop_front());
    if (mb4.arvalid[0] && mb4.arready[0] && g4_ar.size() > 0) check("grant4_ar", mb4.araddr, g4_ar.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int tgt;
    sb.awaddr = '0; sb.awlen = '0; sb.awsize = {2{3'd2}}; sb.awburst = {2{2'd1}};
    sb.awvalid = 2'b11; sb.wdata = '0; sb.wstrb = '1; sb.wlast = '0; sb.wvalid = '0;
    sb.bready = '0; sb.araddr = '0; sb.arlen = '0; sb.arsize = {2{3'd2}};
    sb.arburst = {2{2'd1}}; sb.arvalid = 2'b11; sb.rready = '0;
    mb.wready = 1'b1;
    sb4.awaddr = {32'd3, 32'd2, 32'd1, 32'd0}; sb4.araddr = {32'd3, 32'd2, 32'd1, 32'd0};
    sb4.awlen = '0; sb4.arlen = '0; sb4.awsize = '0; sb4.arsize = '0;
    sb4.awburst = '0; sb4.arburst = '0; sb4.wdata = '0; sb4.wstrb = '1;
    sb4.awvalid = 4'hF; sb4.wvalid = 4'hF; sb4.wlast = 4'hF; sb4.bready = 4'hF;
    sb4.arvalid = 4'hF; sb4.rready = 4'hF;
    mb4.awready = 1'b1; mb4.wready = 1'b1; mb4.bvalid = 1'b1; mb4.bresp = 2'b00;
    mb4.arready = 1'b1; mb4.rvalid = 1'b1; mb4.rlast = 1'b1; mb4.rdata = '0; mb4.rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      g4_aw.push_back(32'(i % 4));
      g4_ar.push_back(32'(i % 4));
    end

    // Requests held during reset must not produce any valid/ready.
    tick(3);
    check("reset_outputs", all_sigs(), 64'd0);
    check("reset_wlast_err", wlast_err, 64'd0);
    sb.awvalid = 2'b00; sb.arvalid = 2'b00;
    rst = 1'b1;
    tick(2);

    // Simultaneous AW: M0 first, then M1; pointer back at 0 afterwards.
    exp_aw.push_back(32'h1000); exp_aw.push_back(32'h2000);
    push_w(32'hA0, 3); push_w(32'hB0, 3);
    exp_b.push_back(0); exp_b.push_back(1);
    fork
      do_write(0, 32'h1000, 3, 3, 32'hA0);
      do_write(1, 32'h2000, 3, 3, 32'hB0);
    join
    exp_aw.push_back(32'h3000); exp_aw.push_back(32'h4000);
    push_w(32'hC0, 0); push_w(32'hD0, 0);
    exp_b.push_back(0); exp_b.push_back(1);
    fork
      do_write(0, 32'h3000, 0, 0, 32'hC0);
      do_write(1, 32'h4000, 0, 0, 32'hD0);
    join

    // Concurrent M1 single-beat write and M0 8-beat read.
    exp_aw.push_back(32'h5000); push_w(32'hE0, 0); exp_b.push_back(1);
    for (int i = 0; i < 8; i++) exp_r.push_back('{0, 32'h8000 + i, i == 7});
    fork
      do_write(1, 32'h5000, 0, 0, 32'hE0);
      do_read(0, 32'h8000, 7);
    join

    // Slave back-pressure for 5 cycles after the first beat.
    exp_aw.push_back(32'h6000); push_w(32'hF0, 3); exp_b.push_back(0);
    tgt = w_seen + 1;
    fork
      do_write(0, 32'h6000, 3, 3, 32'hF0);
      begin
        n = 0;
        while (w_seen < tgt && n < 200) begin
          @(posedge clk);
          n++;
        end
        if (w_seen < tgt) flag("stall_start", "first beat never seen");
        #1;
        mb.wready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_s_wready", sb.wready[0], 64'd0);
        end
        @(posedge clk); #1;
        mb.wready = 1'b1;
      end
    join
    check("good_wlast_err", wlast_err, 64'd0);

    // Early wlast on beat 2 of a 4-beat burst; flag is sticky.
    exp_aw.push_back(32'h7000); push_w(32'h10, 1); exp_b.push_back(0);
    do_write(0, 32'h7000, 3, 1, 32'h10);
    check("early_wlast_err", wlast_err, 64'd1);
    exp_aw.push_back(32'h7100); push_w(32'h40, 1); exp_b.push_back(1);
    do_write(1, 32'h7100, 1, 1, 32'h40);
    check("sticky_wlast_err", wlast_err, 64'd1);

    // Reset asserted while beat 2 of an M0 burst is offered.
    exp_aw.push_back(32'h9000); exp_w.push_back('{32'h20, 1'b0});
    sb.awaddr[31:0] = 32'h9000; sb.awlen[7:0] = 8'd3; sb.awvalid[0] = 1'b1;
    wait_hs(0, 0, "aw_wait_rst");
    @(posedge clk); #1;
    sb.awvalid[0] = 1'b0; sb.wdata[31:0] = 32'h20; sb.wlast[0] = 1'b0; sb.wvalid[0] = 1'b1;
    wait_hs(1, 0, "w_wait_rst");
    @(posedge clk); #1;
    sb.wdata[31:0] = 32'h21;
    #1;
    check("mid_burst_s_wready", sb.wready[0], 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", all_sigs(), 64'd0);
    check("rst_mid_wlast_err", wlast_err, 64'd0);
    sb.wvalid[0] = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    exp_aw.push_back(32'hA000); push_w(32'h30, 1); exp_b.push_back(1);
    do_write(1, 32'hA000, 1, 1, 32'h30);
    tick(3);

    check("exp_w_drained", exp_w.size(), 64'd0);
    check("exp_aw_drained", exp_aw.size(), 64'd0);
    check("exp_b_drained", exp_b.size(), 64'd0);
    check("exp_r_drained", exp_r.size(), 64'd0);
    check("grant4_aw_drained", g4_aw.size(), 64'd0);
    check("grant4_ar_drained", g4_ar.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
